// File: rtl/atomic_warp_serializer.sv
// rtl/atomic_warp_serializer.sv - warp atomic to single-lane RMW request serializer
// Optional: ATOMIC_COALESCE_EN merges same-address FETCH_ADD lanes into one request.
module atomic_warp_serializer #(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_op,
    input  logic [LANES-1:0]            in_mask,
    input  logic [LANES*ADDR_WIDTH-1:0] in_addr,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [LANES*DATA_WIDTH-1:0] in_cmp,
    output logic                        rmw_req_valid,
    input  logic                        rmw_req_ready,
    output logic [ADDR_WIDTH-1:0]       rmw_req_addr,
    output logic [1:0]                  rmw_req_op,
    output logic [DATA_WIDTH-1:0]       rmw_req_data,
    output logic [DATA_WIDTH-1:0]       rmw_req_cmp,
    input  logic                        rmw_resp_valid,
    input  logic [DATA_WIDTH-1:0]       rmw_resp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_mask,
    output logic [LANES*DATA_WIDTH-1:0] out_data
);
    localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [1:0]                  op_r;
    logic [LANES-1:0]            mask_r, pending, issued, group;
    logic [LANES*ADDR_WIDTH-1:0] addr_r;
    logic [LANES*DATA_WIDTH-1:0] data_r, cmp_r, result, lane_resp;
    logic                        out_valid_r;
    logic [SW-1:0]               sel;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [DATA_WIDTH-1:0]       group_data;

    // Lowest pending lane goes first, giving reproducible ascending order.
    always_comb begin
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pending[i]) sel = SW'(i);
        end
        sel_addr = addr_r[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    end

`ifdef ATOMIC_COALESCE_EN
    logic [DATA_WIDTH-1:0] acc;

    always_comb begin
        group      = '0;
        group_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pending[i] && (SW'(i) == sel ||
                (op_r == 2'd1 && addr_r[i*ADDR_WIDTH +: ADDR_WIDTH] == sel_addr))) begin
                group[i]   = 1'b1;
                group_data = group_data + data_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Each merged lane sees the old value plus the addends of lower merged lanes.
    always_comb begin
        acc       = '0;
        lane_resp = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_resp[i*DATA_WIDTH +: DATA_WIDTH] = rmw_resp_data + acc;
            if (issued[i]) acc = acc + data_r[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`else
    always_comb begin
        group      = '0;
        group[sel] = 1'b1;
        group_data = data_r[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign lane_resp = {LANES{rmw_resp_data}};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if ((in_op == 2'd1 || in_op == 2'd2) && |in_mask) state_next = ISSUE;
                    else                                              state_next = RESP;
                end
            end
            ISSUE: if (rmw_req_ready) state_next = WAIT;
            WAIT: begin
                if (rmw_resp_valid) begin
                    if (|(pending & ~issued)) state_next = ISSUE;
                    else                      state_next = RESP;
                end
            end
            RESP: if (out_valid_r && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= '0;
            mask_r      <= '0;
            pending     <= '0;
            issued      <= '0;
            addr_r      <= '0;
            data_r      <= '0;
            cmp_r       <= '0;
            result      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r    <= in_op;
                        mask_r  <= in_mask;
                        pending <= in_mask;
                        addr_r  <= in_addr;
                        data_r  <= in_data;
                        cmp_r   <= in_cmp;
                        result  <= '0;
                    end
                end
                ISSUE: if (rmw_req_ready) issued <= group;
                WAIT: begin
                    if (rmw_resp_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (issued[i])
                                result[i*DATA_WIDTH +: DATA_WIDTH] <= lane_resp[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        pending <= pending & ~issued;
                    end
                end
                RESP: out_valid_r <= !(out_valid_r && out_ready);
                default: ;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign rmw_req_valid = (state == ISSUE);
    assign rmw_req_addr  = (state == ISSUE) ? sel_addr : '0;
    assign rmw_req_op    = (state == ISSUE) ? op_r : 2'd0;
    assign rmw_req_data  = (state == ISSUE) ? group_data : '0;
    assign rmw_req_cmp   = (state == ISSUE) ? cmp_r[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign out_valid     = out_valid_r;
    assign out_mask      = mask_r;
    assign out_data      = result;
endmodule
